// File: rtl/mem_interface_pkg.sv
// Shared definitions for the memory interface block.
//   state_t     : transaction FSM states
//   ADDR_W_DEF  : default memory word-address width
//   TIMEOUT_DEF : default number of wait cycles for mem_ack before abort
package mem_interface_pkg;

  localparam int unsigned ADDR_W_DEF  = 9;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Wait-cycle counter for memory transactions.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   clr   : synchronous clear to zero (has priority over en)
//   en    : count one more cycle without acknowledge
//   tc    : terminal count, high while the count equals TIMEOUT-1
module mem_wait_counter
  import mem_interface_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    // NOTE: assign a default first so every path writes count_d; otherwise a latch is inferred.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == LAST);

endmodule

// File: rtl/mem_interface.sv
// Memory interface: MAR/MDR registers plus a request/acknowledge FSM with
// timeout, sitting between a bus-mux datapath and a word-addressed memory.
//   Clock, Clear           : clock, asynchronous active-low reset
//   BusMuxOut, MARin, MDRin: datapath bus value and register load strobes
//   Read, Write            : transaction start requests (Read wins if both)
//   MDRdataOut             : MDR contents back to the bus mux
//   Busy, Done, Err        : in-flight flag, end-of-transaction pulse, sticky timeout
//   mem_addr, mem_wdata    : MAR and MDR driven to memory
//   mem_req, mem_we        : request held until ack/timeout, write qualifier
//   mem_rdata, mem_ack     : read data and completion strobe from memory
module mem_interface
  import mem_interface_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic [31:0]       BusMuxOut,
  input  logic              MARin,
  input  logic              MDRin,
  input  logic              Read,
  input  logic              Write,
  output logic [31:0]       MDRdataOut,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_req,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
);

  state_t            state_d, state_q;
  logic [ADDR_W-1:0] mar_d, mar_q;
  logic [31:0]       mdr_d, mdr_q;
  logic              err_d, err_q;
  logic              done_d, done_q;
  logic              busy_d, busy_q;
  logic              req_d, req_q;
  logic              we_d, we_q;
  logic              wait_tc;
  logic              in_xfer;

  assign in_xfer = (state_q == ST_RD) || (state_q == ST_WR);

  // Held clear in IDLE so the count starts at zero on entering RD/WR; only
  // cycles spent waiting without an ack advance it.
  mem_wait_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_wait (
    .clk  (Clock),
    .rst_n(Clear),
    .clr  (state_q == ST_IDLE),
    .en   (in_xfer && !mem_ack),
    .tc   (wait_tc)
  );

  always_comb begin
    state_d = state_q;
    mar_d   = mar_q;
    mdr_d   = mdr_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (MARin) mar_d = BusMuxOut[ADDR_W-1:0];
        // A read in the same cycle owns MDR, so the bus load is suppressed.
        if (MDRin && !Read) mdr_d = BusMuxOut;
        if (Read) begin
          state_d = ST_RD;
          err_d   = 1'b0;
        end else if (Write) begin
          state_d = ST_WR;
          err_d   = 1'b0;
        end
      end
      ST_RD: begin
        if (mem_ack) begin
          mdr_d   = mem_rdata;
          state_d = ST_DONE;
        end else if (wait_tc) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_WR: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (wait_tc) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they line
    // up with the state they describe and have no input-to-output path.
    busy_d = (state_d != ST_IDLE);
    req_d  = (state_d == ST_RD) || (state_d == ST_WR);
    we_d   = (state_d == ST_WR);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state_q <= ST_IDLE;
      mar_q   <= '0;
      mdr_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
      err_q   <= err_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      req_q   <= req_d;
      we_q    <= we_d;
    end
  end

  assign MDRdataOut = mdr_q;
  assign mem_wdata  = mdr_q;
  assign mem_addr   = mar_q;
  assign Busy       = busy_q;
  assign Done       = done_q;
  assign Err        = err_q;
  assign mem_req    = req_q;
  assign mem_we     = we_q;

endmodule
